// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - four-digit 7-segment scan multiplexer with frame-synchronous data commit
// Feeds the BCD decoder's val input and drives anodes/decimal point one clock later to match its register.
module display_scan_mux #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  val,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic        upd
);

  localparam int              CW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    idx_q,   idx_d;
  logic [15:0]   disp_q,  disp_d;
  logic [3:0]    dmask_q, dmask_d;
  logic [15:0]   pend_q,  pend_d;
  logic [3:0]    pmask_q, pmask_d;
  logic          pv_q,    pv_d;
  logic [3:0]    val_q,   val_d;
  logic [3:0]    an_q,    an_d;
  logic          dp_n_q,  dp_n_d;
  logic          upd_q,   upd_d;

  logic tick;
  logic boundary;
  logic blank_cur;

  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    boundary = tick && (idx_q == 2'd3);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;

    disp_d   = disp_q;
    dmask_d  = dmask_q;
    pend_d   = pend_q;
    pmask_d  = pmask_q;
    pv_d     = pv_q;
    upd_d    = 1'b0;

    // Data only reaches the display register at a frame boundary so a frame never mixes two words.
    if (boundary) begin
      if (load) begin
        disp_d  = data;
        dmask_d = dp_in;
        pv_d    = 1'b0;
        upd_d   = 1'b1;
      end else if (pv_q) begin
        disp_d  = pend_q;
        dmask_d = pmask_q;
        pv_d    = 1'b0;
        upd_d   = 1'b1;
      end
    end else if (load) begin
      pend_d  = data;
      pmask_d = dp_in;
      pv_d    = 1'b1;
    end

    // val looks ahead at next-state idx/disp so the decoder output lands with the new anode.
    val_d = disp_d[{idx_d, 2'b00} +: 4];

    unique case (idx_q)
      2'd1:    blank_cur = blank_lz && (disp_q[15:4]  == 12'h000);
      2'd2:    blank_cur = blank_lz && (disp_q[15:8]  == 8'h00);
      2'd3:    blank_cur = blank_lz && (disp_q[15:12] == 4'h0);
      default: blank_cur = 1'b0;
    endcase

    an_d   = blank_cur ? 4'b1111 : ~(4'b0001 << idx_q);
    dp_n_d = blank_cur | ~dmask_q[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      disp_q  <= 16'h0000;
      dmask_q <= 4'h0;
      pend_q  <= 16'h0000;
      pmask_q <= 4'h0;
      pv_q    <= 1'b0;
      val_q   <= 4'h0;
      an_q    <= 4'b1111;
      dp_n_q  <= 1'b1;
      upd_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      dmask_q <= dmask_d;
      pend_q  <= pend_d;
      pmask_q <= pmask_d;
      pv_q    <= pv_d;
      val_q   <= val_d;
      an_q    <= an_d;
      dp_n_q  <= dp_n_d;
      upd_q   <= upd_d;
    end
  end

  assign val  = val_q;
  assign an   = an_q;
  assign dp_n = dp_n_q;
  assign upd  = upd_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - self-checking bench for display_scan_mux
module tb_display_scan_mux;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  val;
  logic [3:0]  an;
  logic        dp_n;
  logic        upd;

  display_scan_mux #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .val(val), .an(an), .dp_n(dp_n), .upd(upd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: edge count since reset and the committed/pending words.
  int          m_e;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dmask, m_pmask;
  logic        m_pv;
  logic        cur_bl;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        bl;
    logic [15:0] exp_val;
    logic [15:0] exp_an;
    logic [3:0]  exp_dpn;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, m_e);
  endtask

  task automatic model_reset();
    m_e = 0; m_disp = 16'h0; m_pend = 16'h0; m_dmask = 4'h0; m_pmask = 4'h0; m_pv = 1'b0;
  endtask

  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dp, input logic bl);
    int          prev_e, cur, nxt;
    logic [15:0] old_disp;
    logic [3:0]  old_dmask;
    logic        e_upd, blanked;
    logic [3:0]  e_val, e_an;
    logic        e_dpn;
    load = ld; data = d; dp_in = dp; blank_lz = bl;
    @(posedge clk);
    #1;
    prev_e = m_e; old_disp = m_disp; old_dmask = m_dmask;
    m_e++;
    e_upd = 1'b0;
    if (m_e % FRAME == 0) begin
      if (ld) begin
        m_disp = d; m_dmask = dp; m_pv = 1'b0; e_upd = 1'b1;
      end else if (m_pv) begin
        m_disp = m_pend; m_dmask = m_pmask; m_pv = 1'b0; e_upd = 1'b1;
      end
    end else if (ld) begin
      m_pend = d; m_pmask = dp; m_pv = 1'b1;
    end
    cur = (prev_e / DIV) % 4;
    nxt = (m_e / DIV) % 4;
    e_val   = 4'((m_disp >> (4 * nxt)) & 16'h000F);
    blanked = bl && (cur != 0) && ((old_disp >> (4 * cur)) == 16'h0);
    e_an    = blanked ? 4'b1111 : 4'(~(4'b0001 << cur));
    e_dpn   = blanked ? 1'b1 : ~old_dmask[cur];
    check("model_val", {12'h0, val}, {12'h0, e_val});
    check("model_an", {12'h0, an}, {12'h0, e_an});
    check("model_dp_n", {15'h0, dp_n}, {15'h0, e_dpn});
    check("model_upd", {15'h0, upd}, {15'h0, e_upd});
    load = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 16'($urandom), 4'($urandom), cur_bl);
  endtask

  initial begin
    int upd_cnt1, upd_cnt2;
    tbl[0] = '{16'h1234, 4'b0100, 1'b0, 16'h1234, 16'h7BDE, 4'b1011};
    tbl[1] = '{16'h0070, 4'b0000, 1'b1, 16'h0070, 16'hFFDE, 4'b1111};
    tbl[2] = '{16'h0000, 4'b1111, 1'b1, 16'h0000, 16'hFFFE, 4'b1110};
    tbl[3] = '{16'h0070, 4'b0000, 1'b0, 16'h0070, 16'h7BDE, 4'b1111};
    tbl[4] = '{16'hABCD, 4'b0000, 1'b1, 16'hABCD, 16'h7BDE, 4'b1111};
    tbl[5] = '{16'h0100, 4'b1000, 1'b1, 16'h0100, 16'hFBDE, 4'b1111};
    cur_bl = 1'b0;
    model_reset();

    // Reset state, then first edge after release.
    @(negedge clk);
    check("rst_val", {12'h0, val}, 16'h0);
    check("rst_an", {12'h0, an}, 16'hF);
    check("rst_dp_n", {15'h0, dp_n}, 16'h1);
    check("rst_upd", {15'h0, upd}, 16'h0);
    rst_n = 1'b1;
    step(1'b0, 16'h0, 4'h0, 1'b0);
    check("first_an", {12'h0, an}, 16'hE);

    // Put visible data up, then reset asynchronously mid-slot.
    step(1'b1, 16'h5555, 4'hF, 1'b0);
    while (m_e < FRAME + 2) idle();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_an", {12'h0, an}, 16'hF);
    check("async_rst_val", {12'h0, val}, 16'h0);
    check("async_rst_dp_n", {15'h0, dp_n}, 16'h1);
    @(posedge clk);
    #1;
    check("held_rst_an", {12'h0, an}, 16'hF);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 16'h0, 4'h0, 1'b0);
    check("rerel_an", {12'h0, an}, 16'hE);

    // Table: load mid-frame, then sample every digit slot of the next frame.
    for (int i = 0; i < 6; i++) begin
      int base;
      cur_bl = tbl[i].bl;
      while ((m_e + 1) % FRAME != DIV + 2) idle();
      step(1'b1, tbl[i].data, tbl[i].dp, cur_bl);
      while (m_e % FRAME != 0) idle();
      check("tbl_upd", {15'h0, upd}, 16'h1);
      base = m_e;
      for (int k = 1; k <= FRAME; k++) begin
        idle();
        if ((k - 1) % DIV == 0) begin
          int s;
          s = (k - 1) / DIV;
          check("tbl_val", {12'h0, val}, {12'h0, tbl[i].exp_val[4*s +: 4]});
          check("tbl_an", {12'h0, an}, {12'h0, tbl[i].exp_an[4*s +: 4]});
          check("tbl_dp_n", {15'h0, dp_n}, {15'h0, tbl[i].exp_dpn[s]});
        end
      end
      if (m_e != base + FRAME) check("tbl_align", 16'(m_e), 16'(base + FRAME));
    end

    // Load exactly in the boundary cycle bypasses the pending register.
    cur_bl = 1'b0;
    while ((m_e + 1) % FRAME != 0) idle();
    step(1'b1, 16'h9876, 4'h0, cur_bl);
    check("bypass_upd", {15'h0, upd}, 16'h1);
    check("bypass_val", {12'h0, val}, 16'h6);
    idle();
    check("bypass_upd_drop", {15'h0, upd}, 16'h0);

    // Two loads in one frame: last wins, single upd; following empty frame has no upd.
    while ((m_e + 1) % FRAME != 2) idle();
    step(1'b1, 16'h1111, 4'h0, cur_bl);
    repeat (3) idle();
    step(1'b1, 16'h2222, 4'h0, cur_bl);
    upd_cnt1 = 0;
    upd_cnt2 = 0;
    for (int k = 0; k < FRAME; k++) begin idle(); upd_cnt1 += int'(upd); end
    for (int k = 0; k < FRAME; k++) begin idle(); upd_cnt2 += int'(upd); end
    check("two_load_upd_cnt", 16'(upd_cnt1), 16'd1);
    check("no_load_upd_cnt", 16'(upd_cnt2), 16'd0);
    check("two_load_val", {12'h0, val}, 16'h2);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 31) == 0) cur_bl = ~cur_bl;
      step($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom), cur_bl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
